timestamp_read_arbiter: RTL and testbench
=========================================

Name: timestamp_read_arbiter

Overview:
- Shares one 8-byte timestamp readout path among NUM_CHN per-channel timestamp FIFOs, all read in the rclk domain.
- Arbitrates channel requests round-robin and issues a one-cycle read strobe to the granted FIFO.
- Captures that FIFO's 8 output bytes and forwards them as one framed byte stream, tagged with the channel number.
- Sits between the channel timestamp FIFOs and the consumer that inserts timestamps into the image/event stream.

Parameters:
- CHN_BITS, 2, channel index width; NUM_CHN = 2**CHN_BITS (legal CHN_BITS range 1..4).
- TS_LAT, 2, rclk cycles from a FIFO read strobe to that FIFO's byte 0 on ts_din; legal range 1..7.
- GAP, 2, idle rclk cycles enforced after the last byte of a transfer; legal range 0..15.

Ports:
- rclk  in  1  single clock for the whole block.
- rrst_n  in  1  reset, asynchronous, active-low.
- req  in  NUM_CHN  per-channel level request, held by the requester until its ack.
- ack  out  NUM_CHN  one-cycle pulse to the served channel.
- rstb  out  NUM_CHN  one-hot, one-cycle read strobe to the channel FIFOs.
- ts_din  in  8*NUM_CHN  concatenated FIFO byte outputs; channel c occupies bits [8c+7:8c].
- dout  out  8  forwarded timestamp byte.
- dv  out  1  dout valid.
- dstart  out  1  marks byte 0 of a transfer.
- dlast  out  1  marks byte 7 of a transfer.
- dchn  out  CHN_BITS  channel being forwarded; valid while dv=1.
- busy  out  1  high from grant through the end of the gap period.

Behaviour:
- Reset (rrst_n=0, asynchronous): all outputs go to 0 immediately, state=IDLE, round-robin pointer=0, counters=0.
- Reset asserted mid-transfer aborts the transfer; no ack is issued for the aborted channel.
- All outputs are registered.
- States:
  - IDLE: on any req bit set, grant the lowest index c such that c >= ptr (modulo NUM_CHN). Then ptr <= c+1 (wraps), latch chn=c, go to STRB.
  - STRB: one cycle; rstb[c]=1, busy=1. Go to WAIT.
  - WAIT: wait until cycle T0+TS_LAT, where T0 is the STRB cycle, then go to XFER.
  - XFER: 8 cycles, byte counter k=0..7. Sample ts_din[8c+7:8c] at T0+TS_LAT+k and present it on dout at T0+TS_LAT+1+k with dv=1, dchn=c. dstart=1 when k=0; dlast=1 and ack[c]=1 when k=7.
  - GAP: GAP cycles with dv=0 and busy=1, then go to IDLE. GAP=0 goes straight to IDLE.
- busy=1 in STRB, WAIT, XFER and GAP; busy=0 in IDLE.
- Timing:
  - req sampled high in IDLE gives rstb on the next cycle.
  - Minimum rstb-to-rstb spacing is TS_LAT+GAP+10 cycles (14 with defaults).
- Requests:
  - req is examined only in IDLE.
  - req deasserted after grant does not abort the transfer; ack still pulses.
  - req deasserted before grant is simply not served.
  - A requester must drop req within 1 cycle of ack; otherwise it is treated as a new request.
- Simultaneous requests are served in strict round-robin order starting from ptr. No channel waits more than NUM_CHN-1 transfers.
- ts_din of non-granted channels is ignored. dout holds its last value when dv=0.

Test Plan:
- Reset, then req=4'b0100 at cycle 0:
  - rstb=4'b0100 at cycle 1.
  - dv high cycles 4..11, dout = ts_din[23:16] sampled at cycles 3..10.
  - dstart at cycle 4; dlast and ack[2] at cycle 11; dchn=2.
  - busy=0 at cycle 14.
- req=4'b1111 held, each requester dropping req on its own ack:
  - grants in order 0,1,2,3.
  - rstb pulses at cycles 1, 15, 29, 43.
  - ptr wraps to 0.
- ptr=3 after serving chn2, then req=4'b1001: chn3 is served before chn0.
- Reset pulsed low during XFER byte 4:
  - dv, rstb, ack go to 0 immediately; no ack.
  - a subsequent req=4'b0001 is served starting with ptr=0.
- Requester drops req two cycles after rstb: all 8 bytes still forwarded and ack still pulses.
- GAP=0, TS_LAT=1, req[1] held continuously:
  - consecutive rstb pulses are 11 cycles apart.
  - dv is low for exactly 3 cycles between transfers.

Source files
------------

// File: rtl/timestamp_read_arbiter_if.sv
// Bundle between the channel timestamp FIFOs/requesters and the timestamp read arbiter.
// req/ack: req is a level held by the requester; ack pulses one cycle when its 8 bytes have gone out.
interface timestamp_read_arbiter_if #(
   parameter int CHN_BITS = 2
);
   localparam int NUM_CHN = 2**CHN_BITS;

   logic [NUM_CHN-1:0]   req;
   logic [NUM_CHN-1:0]   ack;
   logic [NUM_CHN-1:0]   rstb;
   logic [8*NUM_CHN-1:0] ts_din;
   logic [7:0]           dout;
   logic                 dv;
   logic                 dstart;
   logic                 dlast;
   logic [CHN_BITS-1:0]  dchn;
   logic                 busy;

   modport master (
      input  req, ts_din,
      output ack, rstb, dout, dv, dstart, dlast, dchn, busy
   );

   modport slave (
      output req, ts_din,
      input  ack, rstb, dout, dv, dstart, dlast, dchn, busy
   );
endinterface

// File: rtl/timestamp_read_arbiter.sv
// Round-robin arbiter that strobes one channel timestamp FIFO at a time and forwards its
// 8 output bytes as a framed, channel-tagged byte stream. All outputs are registered.
module timestamp_read_arbiter #(
   parameter int CHN_BITS = 2,
   parameter int TS_LAT   = 2,
   parameter int GAP      = 2
) (
   input  logic                     rclk,
   input  logic                     rrst_n,
   timestamp_read_arbiter_if.master bus,
   output logic [2:0]               fsm_state
);
   localparam int NUM_CHN = 2**CHN_BITS;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      STRB = 3'd1,
      WAIT = 3'd2,
      XFER = 3'd3,
      GAPS = 3'd4
   } state_t;

   state_t              state, state_nx;
   logic [3:0]          cnt;
   logic [CHN_BITS-1:0] ptr, chn, gnt, idx;
   logic                found, req_any;

   logic [NUM_CHN-1:0]  rstb_nx, ack_nx;
   logic [7:0]          dout_nx;
   logic [CHN_BITS-1:0] dchn_nx;
   logic                dv_nx, dstart_nx, dlast_nx, busy_nx;

   assign req_any   = |bus.req;
   assign fsm_state = state;

   // First requesting channel at or after ptr, wrapping modulo NUM_CHN.
   always_comb begin
      found = 1'b0;
      gnt   = ptr;
      idx   = '0;
      for (int i = 0; i < NUM_CHN; i++) begin
         idx = ptr + CHN_BITS'(i);
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            gnt   = idx;
         end
      end
   end

   // cnt restarts on every state change, so it serves as wait, byte and gap counter.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state <= IDLE;
         cnt   <= '0;
         ptr   <= '0;
         chn   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= (state_nx != state) ? 4'd0 : cnt + 4'd1;
         if (state == IDLE && req_any) begin
            chn <= gnt;
            ptr <= gnt + 1'b1;
         end
      end
   end

   // GAPS also covers the cycle that shows the last byte, hence GAP+1 cycles there.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (req_any) state_nx = STRB;
         STRB: state_nx = (TS_LAT > 1) ? WAIT : XFER;
         WAIT: if (int'(cnt) >= TS_LAT - 2) state_nx = XFER;
         XFER: if (cnt == 4'd7) state_nx = GAPS;
         GAPS: if (int'(cnt) >= GAP) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      rstb_nx   = (state == IDLE && req_any) ? (NUM_CHN'(1) << gnt) : '0;
      dv_nx     = (state == XFER);
      dstart_nx = dv_nx && (cnt == 4'd0);
      dlast_nx  = dv_nx && (cnt == 4'd7);
      ack_nx    = dlast_nx ? (NUM_CHN'(1) << chn) : '0;
      busy_nx   = (state_nx != IDLE);
      dout_nx   = dv_nx ? bus.ts_din[{chn, 3'b000} +: 8] : bus.dout;
      dchn_nx   = dv_nx ? chn : bus.dchn;
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         bus.rstb   <= '0;
         bus.ack    <= '0;
         bus.dout   <= '0;
         bus.dv     <= 1'b0;
         bus.dstart <= 1'b0;
         bus.dlast  <= 1'b0;
         bus.dchn   <= '0;
         bus.busy   <= 1'b0;
      end else begin
         bus.rstb   <= rstb_nx;
         bus.ack    <= ack_nx;
         bus.dout   <= dout_nx;
         bus.dv     <= dv_nx;
         bus.dstart <= dstart_nx;
         bus.dlast  <= dlast_nx;
         bus.dchn   <= dchn_nx;
         bus.busy   <= busy_nx;
      end
   end
endmodule

// File: tb/tb_timestamp_read_arbiter.sv
// Directed bench for timestamp_read_arbiter: a default instance (TS_LAT=2, GAP=2) and a
// fast instance (TS_LAT=1, GAP=0); FIFO bytes are a known function of channel and cycle.
module tb_timestamp_read_arbiter;
   localparam int CB = 2;

   logic        rclk;
   logic        rrst_n;
   int          cyc;
   int          total = 0;
   int          bad   = 0;
   logic [2:0]  st1, st2;
   logic [11:0] ctl1, ctl2, exp;

   timestamp_read_arbiter_if #(.CHN_BITS(CB)) bus ();
   timestamp_read_arbiter_if #(.CHN_BITS(CB)) bus2 ();

   timestamp_read_arbiter #(.CHN_BITS(CB), .TS_LAT(2), .GAP(2)) dut (
      .rclk(rclk), .rrst_n(rrst_n), .bus(bus), .fsm_state(st1)
   );
   timestamp_read_arbiter #(.CHN_BITS(CB), .TS_LAT(1), .GAP(0)) dut2 (
      .rclk(rclk), .rrst_n(rrst_n), .bus(bus2), .fsm_state(st2)
   );

   assign ctl1 = {bus.rstb, bus.ack, bus.dv, bus.dstart, bus.dlast, bus.busy};
   assign ctl2 = {bus2.rstb, bus2.ack, bus2.dv, bus2.dstart, bus2.dlast, bus2.busy};

   function automatic logic [7:0] pat(int c, int n);
      return 8'(c * 64 + n * 3 + 1);
   endfunction

   // Expected {rstb, ack, dv, dstart, dlast, busy} d cycles after a strobe to channel c.
   function automatic logic [11:0] model(int d, int c, int lat, int gap);
      logic [3:0]  oh;
      logic [11:0] r;
      oh = 4'b0001 << c;
      r  = '0;
      if (d == 0) r[11:8] = oh;
      if (d == lat + 8) r[7:4] = oh;
      r[3] = (d >= lat + 1 && d <= lat + 8);
      r[2] = (d == lat + 1);
      r[1] = (d == lat + 8);
      r[0] = (d >= 0 && d <= lat + gap + 8);
      return r;
   endfunction

   // Clock plus FIFO model: during cycle cyc each channel presents pat(c, cyc).
   initial begin
      rclk = 1'b0;
      cyc  = 0;
      for (int c = 0; c < 4; c++) begin
         bus.ts_din[8*c +: 8]  = pat(c, 0);
         bus2.ts_din[8*c +: 8] = pat(c, 0);
      end
      forever begin
         #5 rclk = 1'b1;
         #1 cyc++;
         for (int c = 0; c < 4; c++) begin
            bus.ts_din[8*c +: 8]  = pat(c, cyc);
            bus2.ts_din[8*c +: 8] = pat(c, cyc);
         end
         #4 rclk = 1'b0;
      end
   end

   task automatic test_reset();
      rrst_n   = 1'b0;
      bus.req  = '0;
      bus2.req = '0;
      @(negedge rclk);
      @(negedge rclk);
      total++;
      if ({ctl1, bus.dout, bus.dchn, st1} !== '0) begin
         $display("FAIL reset_outputs got=%h required=0", {ctl1, bus.dout, bus.dchn, st1});
         bad++;
      end
      total++;
      if ({ctl2, bus2.dout, bus2.dchn, st2} !== '0) begin
         $display("FAIL reset_outputs2 got=%h required=0", {ctl2, bus2.dout, bus2.dchn, st2});
         bad++;
      end
      rrst_n = 1'b1;
      @(negedge rclk);
   endtask

   task automatic test_basic();
      bus.req = 4'b0100;
      for (int n = 0; n < 15; n++) begin
         exp = model(n - 1, 2, 2, 2);
         total++;
         if (ctl1 !== exp) begin
            $display("FAIL basic_ctl n=%0d got=%b required=%b", n, ctl1, exp);
            bad++;
         end
         if (exp[3]) begin
            total++;
            if (bus.dout !== pat(2, cyc - 1) || bus.dchn !== 2'd2) begin
               $display("FAIL basic_data n=%0d got=%h/%0d required=%h/2", n, bus.dout, bus.dchn, pat(2, cyc - 1));
               bad++;
            end
         end
         if (n == 11) bus.req = '0;
         @(negedge rclk);
      end
   endtask

   task automatic test_ptr_order();
      logic [1:0] ec;
      bus.req = 4'b1001;
      for (int n = 0; n < 30; n++) begin
         exp = model(n - 1, 3, 2, 2) | model(n - 15, 0, 2, 2);
         ec  = (n < 15) ? 2'd3 : 2'd0;
         total++;
         if (ctl1 !== exp) begin
            $display("FAIL ptr_order_ctl n=%0d got=%b required=%b", n, ctl1, exp);
            bad++;
         end
         if (exp[3]) begin
            total++;
            if (bus.dout !== pat(ec, cyc - 1) || bus.dchn !== ec) begin
               $display("FAIL ptr_order_data n=%0d got=%h/%0d required=%h/%0d", n, bus.dout, bus.dchn, pat(ec, cyc - 1), ec);
               bad++;
            end
         end
         if (n == 11) bus.req[3] = 1'b0;
         if (n == 25) bus.req[0] = 1'b0;
         @(negedge rclk);
      end
   endtask

   task automatic test_req_drop();
      bus.req = 4'b0010;
      for (int n = 0; n < 15; n++) begin
         exp = model(n - 1, 1, 2, 2);
         total++;
         if (ctl1 !== exp) begin
            $display("FAIL req_drop_ctl n=%0d got=%b required=%b", n, ctl1, exp);
            bad++;
         end
         if (exp[3]) begin
            total++;
            if (bus.dout !== pat(1, cyc - 1) || bus.dchn !== 2'd1) begin
               $display("FAIL req_drop_data n=%0d got=%h/%0d required=%h/1", n, bus.dout, bus.dchn, pat(1, cyc - 1));
               bad++;
            end
         end
         if (n == 3) bus.req = '0;
         @(negedge rclk);
      end
   endtask

   task automatic test_reset_mid();
      bus.req = 4'b0100;
      for (int n = 0; n < 8; n++) begin
         exp = model(n - 1, 2, 2, 2);
         total++;
         if (ctl1 !== exp) begin
            $display("FAIL reset_mid_pre n=%0d got=%b required=%b", n, ctl1, exp);
            bad++;
         end
         if (n < 7) @(negedge rclk);
      end
      rrst_n = 1'b0;
      #1;
      total++;
      if ({ctl1, bus.dout, bus.dchn, st1} !== '0) begin
         $display("FAIL reset_mid_async got=%h required=0", {ctl1, bus.dout, bus.dchn, st1});
         bad++;
      end
      @(negedge rclk);
      rrst_n  = 1'b1;
      bus.req = '0;
      for (int n = 0; n < 12; n++) begin
         total++;
         if ({bus.rstb, bus.ack, bus.busy} !== '0) begin
            $display("FAIL reset_mid_noack n=%0d got=%b required=0", n, {bus.rstb, bus.ack, bus.busy});
            bad++;
         end
         @(negedge rclk);
      end
      bus.req = 4'b1001;
      for (int n = 0; n < 15; n++) begin
         exp = model(n - 1, 0, 2, 2);
         total++;
         if (ctl1 !== exp) begin
            $display("FAIL reset_mid_post n=%0d got=%b required=%b", n, ctl1, exp);
            bad++;
         end
         if (n == 1) bus.req[3] = 1'b0;
         if (n == 11) bus.req = '0;
         @(negedge rclk);
      end
   endtask

   task automatic test_round_robin();
      logic [1:0] ec;
      int         k;
      rrst_n = 1'b0;
      @(negedge rclk);
      rrst_n = 1'b1;
      @(negedge rclk);
      bus.req = 4'b1111;
      for (int n = 0; n < 58; n++) begin
         exp = model(n - 57, 0, 2, 2);
         ec  = 2'd0;
         for (int g = 0; g < 4; g++) begin
            exp = exp | model(n - 1 - 14 * g, g, 2, 2);
            if (n - 1 - 14 * g >= 3 && n - 1 - 14 * g <= 10) ec = 2'(g);
         end
         total++;
         if (ctl1 !== exp) begin
            $display("FAIL rr_ctl n=%0d got=%b required=%b", n, ctl1, exp);
            bad++;
         end
         if (exp[3]) begin
            total++;
            if (bus.dout !== pat(ec, cyc - 1) || bus.dchn !== ec) begin
               $display("FAIL rr_data n=%0d got=%h/%0d required=%h/%0d", n, bus.dout, bus.dchn, pat(ec, cyc - 1), ec);
               bad++;
            end
         end
         for (int g = 0; g < 4; g++)
            if (n == 11 + 14 * g) bus.req[g] = 1'b0;
         if (n == 56) bus.req = 4'b0011;
         if (n == 57) bus.req = '0;
         @(negedge rclk);
      end
      k = 0;
      while (bus.busy !== 1'b0 && k < 40) begin
         @(negedge rclk);
         k++;
      end
      total++;
      if (bus.busy !== 1'b0) begin
         $display("FAIL rr_idle_timeout got=%b required=0", bus.busy);
         bad++;
      end
   endtask

   task automatic test_gap0();
      int k;
      bus2.req = 4'b0010;
      for (int n = 0; n < 24; n++) begin
         exp = model(n - 1, 1, 1, 0) | model(n - 12, 1, 1, 0) | model(n - 23, 1, 1, 0);
         total++;
         if (ctl2 !== exp) begin
            $display("FAIL gap0_ctl n=%0d got=%b required=%b", n, ctl2, exp);
            bad++;
         end
         if (exp[3]) begin
            total++;
            if (bus2.dout !== pat(1, cyc - 1) || bus2.dchn !== 2'd1) begin
               $display("FAIL gap0_data n=%0d got=%h/%0d required=%h/1", n, bus2.dout, bus2.dchn, pat(1, cyc - 1));
               bad++;
            end
         end
         if (n == 23) bus2.req = '0;
         @(negedge rclk);
      end
      k = 0;
      while (bus2.busy !== 1'b0 && k < 40) begin
         @(negedge rclk);
         k++;
      end
      total++;
      if (bus2.busy !== 1'b0) begin
         $display("FAIL gap0_idle_timeout got=%b required=0", bus2.busy);
         bad++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ptr_order();
      test_req_drop();
      test_reset_mid();
      test_round_robin();
      test_gap0();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
